// File: rtl/dct_rotate_stage.sv
// DCT stage-2 butterfly: two add/sub butterfly pairs and two fixed-point plane
// rotations in a 3-stage valid/ready pipeline with round-half-up and saturation.
module dct_rotate_stage #(
    parameter int WIDTH     = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 14,
    parameter int C1        = 16069,
    parameter int S1        = 3196,
    parameter int C3        = 13623,
    parameter int S3        = 9102
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [8*WIDTH-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WIDTH-1:0]   out_data,
    output logic                 out_sat
);

    localparam int BW = WIDTH + 1;
    localparam int PW = WIDTH + COEF_W + 1;
    localparam int RW = PW + 1;

    localparam logic signed [PW-1:0] K_C1 = PW'(C1);
    localparam logic signed [PW-1:0] K_S1 = PW'(S1);
    localparam logic signed [PW-1:0] K_C3 = PW'(C3);
    localparam logic signed [PW-1:0] K_S3 = PW'(S3);
    localparam logic signed [RW-1:0] K_RND = RW'(2 ** (COEF_FRAC - 1));

    localparam logic signed [RW-1:0] K_SMAX = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] K_SMIN = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    // Returns {clamped, value} for one lane.
    function automatic logic [WIDTH:0] sat_lane(input logic signed [RW-1:0] v);
        if (v > K_SMAX)
            sat_lane = {1'b1, K_SMAX[WIDTH-1:0]};
        else if (v < K_SMIN)
            sat_lane = {1'b1, K_SMIN[WIDTH-1:0]};
        else
            sat_lane = {1'b0, v[WIDTH-1:0]};
    endfunction

    logic w_ce;

    logic                 r_v1, r_v2, r_v3;
    logic                 r1_mode, r2_mode;
    logic [8*WIDTH-1:0]   r1_data, r2_raw, r3_data;
    logic                 r3_sat;
    logic signed [BW-1:0] r2_a [4];
    logic signed [PW-1:0] r2_p [4];

    logic signed [WIDTH-1:0] w_x   [8];
    logic signed [BW-1:0]    w_a   [4];
    logic signed [PW-1:0]    w_p   [4];
    logic signed [RW-1:0]    w_pre [8];
    logic [WIDTH:0]          w_res [8];
    logic [8*WIDTH-1:0]      w_y;
    logic                    w_any_sat;

    // The whole pipe moves together, so a stall anywhere freezes every stage and lanes stay aligned.
    assign w_ce     = en & (out_ready | ~r_v3);
    assign in_ready = w_ce;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_x[k] = r1_data[k*WIDTH +: WIDTH];
        end
        w_a[0] = BW'(w_x[0]) + BW'(w_x[3]);
        w_a[3] = BW'(w_x[0]) - BW'(w_x[3]);
        w_a[1] = BW'(w_x[1]) + BW'(w_x[2]);
        w_a[2] = BW'(w_x[1]) - BW'(w_x[2]);
        // w_p index j feeds output lane 4+j: p4, p5, p6, p7.
        w_p[0] = PW'(w_x[4]) * K_C3 + PW'(w_x[7]) * K_S3;
        w_p[1] = PW'(w_x[5]) * K_C1 + PW'(w_x[6]) * K_S1;
        w_p[2] = PW'(w_x[6]) * K_C1 - PW'(w_x[5]) * K_S1;
        w_p[3] = PW'(w_x[7]) * K_C3 - PW'(w_x[4]) * K_S3;
    end

    always_comb begin
        w_y       = '0;
        w_any_sat = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_pre[k]     = RW'(r2_a[k]);
            w_pre[k + 4] = (RW'(r2_p[k]) + K_RND) >>> COEF_FRAC;
        end
        for (int k = 0; k < 8; k++) begin
            w_res[k]                = sat_lane(w_pre[k]);
            w_y[k*WIDTH +: WIDTH]   = w_res[k][WIDTH-1:0];
            w_any_sat               = w_any_sat | w_res[k][WIDTH];
        end
    end

    // NOTE: all state uses non-blocking assignments so every stage samples the
    // pre-edge value of the stage before it; data registers are reset as well so
    // out_data reads 0 during reset rather than stale contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r1_mode <= 1'b0;
            r2_mode <= 1'b0;
            r1_data <= '0;
            r2_raw  <= '0;
            r3_data <= '0;
            r3_sat  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r2_a[k] <= '0;
                r2_p[k] <= '0;
            end
        end else if (w_ce) begin
            r_v1    <= in_valid;
            r1_mode <= in_mode;
            r1_data <= in_data;

            r_v2    <= r_v1;
            r2_mode <= r1_mode;
            r2_raw  <= r1_data;
            for (int k = 0; k < 4; k++) begin
                r2_a[k] <= w_a[k];
                r2_p[k] <= w_p[k];
            end

            r_v3    <= r_v2;
            r3_data <= r2_mode ? r2_raw : w_y;
            r3_sat  <= r2_mode ? 1'b0   : w_any_sat;
        end
    end

    assign out_valid = r_v3;
    assign out_data  = r3_data;
    assign out_sat   = r3_sat;

endmodule
